// File: rtl/rep2_pkg.sv
// rep2_pkg: shared types and helpers for the rep2_arbiter slice.
//   rep2_state_t : sequencer states (IDLE, LOAD, CALC, RESP)
//   REP2_W       : default vector width
//   REP2_NREQ    : default number of requesters
//   rep2_popcnt  : population count of a zero-extended result word
package rep2_pkg;

  localparam int REP2_W    = 5;
  localparam int REP2_NREQ = 4;

  // Widest result word rep2_popcnt accepts (covers W up to 8).
  localparam int REP2_POP_MAX = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    RESP = 2'd3
  } rep2_state_t;

  function automatic int unsigned rep2_popcnt(input logic [REP2_POP_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < REP2_POP_MAX; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/rep2_arbiter_if.sv
// rep2_arbiter_if: request / grant / result bundle of rep2_arbiter.
//   req       : per-requester request level
//   vec       : flat requester vectors, requester i at vec[i*W +: W]
//   gnt       : one-hot grant pulse
//   busy      : sequencer not idle
//   res_valid : result held for the consumer
//   res_ready : consumer accepts the result
//   res_id    : index of the served requester
//   res_out   : W*W pairwise-equality word
//   res_cnt   : popcount of res_out (only with REP2_POPCNT_EN defined)
// modport master: requesters + consumer side; modport slave: the arbiter.
interface rep2_arbiter_if
  import rep2_pkg::*;
#(
  parameter int NREQ = REP2_NREQ,
  parameter int W    = REP2_W
);

  logic [NREQ-1:0]          req;
  logic [NREQ*W-1:0]        vec;
  logic [NREQ-1:0]          gnt;
  logic                     busy;
  logic                     res_valid;
  logic                     res_ready;
  logic [$clog2(NREQ)-1:0]  res_id;
  logic [W*W-1:0]           res_out;
`ifdef REP2_POPCNT_EN
  logic [$clog2(W*W+1)-1:0] res_cnt;

  modport master (output req, vec, res_ready,
                  input  gnt, busy, res_valid, res_id, res_out, res_cnt);
  modport slave  (input  req, vec, res_ready,
                  output gnt, busy, res_valid, res_id, res_out, res_cnt);
`else
  modport master (output req, vec, res_ready,
                  input  gnt, busy, res_valid, res_id, res_out);
  modport slave  (input  req, vec, res_ready,
                  output gnt, busy, res_valid, res_id, res_out);
`endif

endinterface

// File: rtl/rep2_core.sv
// rep2_core: combinational pairwise-equality replication.
//   x : W-bit input vector
//   y : W*W-bit word, y[W*W-1-(i*W+j)] = ~(x[W-1-i] ^ x[W-1-j])
// Row i (MSB first) is x[W-1-i] compared against every bit of x.
module rep2_core
  import rep2_pkg::*;
#(
  parameter int W = REP2_W
) (
  input  logic [W-1:0]   x,
  output logic [W*W-1:0] y
);

  always_comb begin
    y = '0;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        y[W*W-1-(i*W+j)] = ~(x[W-1-i] ^ x[W-1-j]);
      end
    end
  end

endmodule

// File: rtl/rep2_arbiter.sv
// rep2_arbiter: round-robin arbiter and sequencer sharing one rep2_core.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : rep2_arbiter_if.slave (req/vec in, gnt/busy/result out)
// Sequence: IDLE (pick) -> LOAD (gnt pulse, capture vec) -> CALC (register
// result) -> RESP (hold until res_ready) -> IDLE.
// Optional macro REP2_POPCNT_EN adds the registered res_cnt output.
module rep2_arbiter
  import rep2_pkg::*;
#(
  parameter int NREQ = REP2_NREQ,
  parameter int W    = REP2_W
) (
  input  logic          clk,
  input  logic          rst,
  rep2_arbiter_if.slave bus
);

  localparam int IDW = $clog2(NREQ);

  rep2_state_t    state, next_state;
  logic [IDW-1:0] rr_ptr, cand, sel, sel_q, res_id;
  logic           any_req, accept;
  logic [NREQ-1:0] gnt, gnt_d;
  logic           busy, busy_d, res_valid, res_valid_d;
  logic [W-1:0]   vec_sel, vec_q;
  logic [W*W-1:0] core_out, res_out;

  rep2_core #(.W(W)) u_core (
    .x (vec_q),
    .y (core_out)
  );

  assign accept = (state == RESP) && bus.res_ready;

  // Cyclic search from rr_ptr upward; iterating downward lets the nearest
  // requester overwrite farther ones.
  // NOTE: every comb output gets a default first so no latch is inferred.
  always_comb begin
    sel     = rr_ptr;
    cand    = '0;
    any_req = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDW'((int'(rr_ptr) + k) % NREQ);
      if (bus.req[cand]) begin
        sel     = cand;
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    vec_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_q == IDW'(i)) vec_sel = bus.vec[i*W +: W];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (any_req) next_state = LOAD;
      LOAD: next_state = CALC;
      CALC: next_state = RESP;
      RESP: if (accept) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from next_state and registered, so they line up
  // with the state they describe without any comb path to the ports.
  always_comb begin
    gnt_d = '0;
    if (state == IDLE && any_req) gnt_d[sel] = 1'b1;
    busy_d      = (next_state != IDLE);
    res_valid_d = (next_state == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt       <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      gnt       <= gnt_d;
      busy      <= busy_d;
      res_valid <= res_valid_d;
    end
  end

  // NOTE: datapath registers are reset too, because res_id/res_out are
  // visible ports with defined reset values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= '0;
      vec_q   <= '0;
      res_id  <= '0;
      res_out <= '0;
      rr_ptr  <= '0;
    end else begin
      if (state == IDLE && any_req) sel_q <= sel;
      if (state == LOAD) begin
        vec_q  <= vec_sel;
        res_id <= sel_q;
      end
      if (state == CALC) res_out <= core_out;
      if (accept) rr_ptr <= (int'(sel_q) == NREQ - 1) ? '0 : sel_q + 1'b1;
    end
  end

`ifdef REP2_POPCNT_EN
  localparam int CW = $clog2(W*W+1);
  logic [CW-1:0] res_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 res_cnt <= '0;
    else if (state == CALC)  res_cnt <= CW'(rep2_popcnt(REP2_POP_MAX'(core_out)));
  end

  assign bus.res_cnt = res_cnt;
`endif

  assign bus.gnt       = gnt;
  assign bus.busy      = busy;
  assign bus.res_valid = res_valid;
  assign bus.res_id    = res_id;
  assign bus.res_out   = res_out;

endmodule

// File: tb/tb_rep2_arbiter.sv
// tb_rep2_arbiter: directed self-checking bench for rep2_arbiter
// (NREQ=4, W=5). Inputs are driven 1 time unit after the rising edge and
// outputs sampled at the same point, away from the active edge.
// res_cnt is checked only when REP2_POPCNT_EN is defined.
module tb_rep2_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 5;

  localparam logic [24:0] OUT_01101 = 25'h126B64D;
  localparam logic [24:0] OUT_10000 = 25'h107BDEF;
  localparam logic [24:0] OUT_EQUAL = 25'h1FFFFFF;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  rep2_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  rep2_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.req       = '0;
    bus.vec       = '0;
    bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", bus.res_valid); end
    checks++; if (bus.res_id !== 2'd0) begin failures++; $display("FAIL reset_id: got %0d want 0", bus.res_id); end
    checks++; if (bus.res_out !== 25'h0) begin failures++; $display("FAIL reset_out: got %h want 0", bus.res_out); end
`ifdef REP2_POPCNT_EN
    checks++; if (bus.res_cnt !== 5'd0) begin failures++; $display("FAIL reset_cnt: got %0d want 0", bus.res_cnt); end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    tick();
    bus.vec = {5'b00000, 5'b11111, 5'b10000, 5'b01101};
    bus.req = 4'b0001;
    tick();  // sampling edge passed: grant cycle
    checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt: got %b want 0001", bus.gnt); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b want 1", bus.busy); end
    bus.req = 4'b0000;
    tick();
    checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL single_gnt_pulse: got %b want 0000", bus.gnt); end
    checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL single_valid_early: got %b want 0", bus.res_valid); end
    tick();
    checks++; if (bus.res_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %b want 1", bus.res_valid); end
    checks++; if (bus.res_out !== OUT_01101) begin failures++; $display("FAIL single_out: got %h want %h", bus.res_out, OUT_01101); end
    checks++; if (bus.res_id !== 2'd0) begin failures++; $display("FAIL single_id: got %0d want 0", bus.res_id); end
`ifdef REP2_POPCNT_EN
    checks++; if (bus.res_cnt !== 5'd13) begin failures++; $display("FAIL single_cnt: got %0d want 13", bus.res_cnt); end
`endif
    bus.res_ready = 1'b1;
    tick();
    checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL single_accept_valid: got %b want 0", bus.res_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL single_accept_busy: got %b want 0", bus.busy); end
    bus.res_ready = 1'b0;
  endtask

  // Requester 2 holds 11111, requester 3 holds 00000; pointer is 1 here.
  task automatic test_all_equal();
    logic [1:0] ids [2] = '{2'd2, 2'd3};
    logic [3:0] exp_g;
    for (int i = 0; i < 2; i++) begin
      exp_g   = 4'b0001 << ids[i];
      bus.req = exp_g;
      tick();
      checks++; if (bus.gnt !== exp_g) begin failures++; $display("FAIL equal_gnt[%0d]: got %b want %b", i, bus.gnt, exp_g); end
      bus.req = 4'b0000;
      tick();
      tick();
      checks++; if (bus.res_valid !== 1'b1) begin failures++; $display("FAIL equal_valid[%0d]: got %b want 1", i, bus.res_valid); end
      checks++; if (bus.res_out !== OUT_EQUAL) begin failures++; $display("FAIL equal_out[%0d]: got %h want %h", i, bus.res_out, OUT_EQUAL); end
      checks++; if (bus.res_id !== ids[i]) begin failures++; $display("FAIL equal_id[%0d]: got %0d want %0d", i, bus.res_id, ids[i]); end
`ifdef REP2_POPCNT_EN
      checks++; if (bus.res_cnt !== 5'd25) begin failures++; $display("FAIL equal_cnt[%0d]: got %0d want 25", i, bus.res_cnt); end
`endif
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
    end
  endtask

  // Pointer is 0 here; all four requesters held with res_ready high.
  task automatic test_round_robin();
    int          ng = 0;
    int          nr = 0;
    int          gcyc [5] = '{-1, -1, -1, -1, -1};
    logic [3:0]  gval [5] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [1:0]  rid  [5] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    logic [24:0] rout [5] = '{25'h0, 25'h0, 25'h0, 25'h0, 25'h0};
    logic [1:0]  exp_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [24:0] exp_out [4] = '{OUT_01101, OUT_10000, OUT_EQUAL, OUT_EQUAL};
    logic [3:0]  exp_g;
    bus.req       = 4'b1111;
    bus.res_ready = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (bus.gnt !== 4'b0000) begin
        if (ng < 5) begin
          gval[ng] = bus.gnt;
          gcyc[ng] = c;
        end
        ng++;
        if (ng == 5) bus.req = 4'b0000;
      end
      if (bus.res_valid === 1'b1) begin
        if (nr < 5) begin
          rid[nr]  = bus.res_id;
          rout[nr] = bus.res_out;
        end
        nr++;
      end
    end
    bus.res_ready = 1'b0;
    checks++; if (ng != 5) begin failures++; $display("FAIL rr_grant_count: got %0d want 5", ng); end
    checks++; if (nr != 5) begin failures++; $display("FAIL rr_result_count: got %0d want 5", nr); end
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'b0001 << exp_id[i];
      checks++; if (gval[i] !== exp_g) begin failures++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, gval[i], exp_g); end
      checks++; if (gcyc[i] != 1 + 4 * i) begin failures++; $display("FAIL rr_spacing[%0d]: got cycle %0d want %0d", i, gcyc[i], 1 + 4 * i); end
      checks++; if (rid[i] !== exp_id[i]) begin failures++; $display("FAIL rr_id[%0d]: got %0d want %0d", i, rid[i], exp_id[i]); end
      checks++; if (rout[i] !== exp_out[exp_id[i]]) begin failures++; $display("FAIL rr_out[%0d]: got %h want %h", i, rout[i], exp_out[exp_id[i]]); end
    end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rr_idle_after: got busy %b want 0", bus.busy); end
  endtask

  // Pointer is 1 here.
  task automatic test_backpressure();
    int          bad = 0;
    bus.req = 4'b0010;
    tick();
    checks++; if (bus.gnt !== 4'b0010) begin failures++; $display("FAIL bp_gnt: got %b want 0010", bus.gnt); end
    bus.req = 4'b1101;  // others keep asking while requester 1 is served
    tick();
    tick();
    checks++; if (bus.res_valid !== 1'b1) begin failures++; $display("FAIL bp_valid: got %b want 1", bus.res_valid); end
    checks++; if (bus.res_out !== OUT_10000) begin failures++; $display("FAIL bp_out: got %h want %h", bus.res_out, OUT_10000); end
    checks++; if (bus.res_id !== 2'd1) begin failures++; $display("FAIL bp_id: got %0d want 1", bus.res_id); end
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.res_valid !== 1'b1 || bus.res_out !== OUT_10000 || bus.res_id !== 2'd1 || bus.gnt !== 4'b0000) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
    bus.res_ready = 1'b1;
    tick();
    checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL bp_complete: got valid %b want 0", bus.res_valid); end
    bus.res_ready = 1'b0;
    checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL bp_idle_gap: got %b want 0000", bus.gnt); end
    tick();
    checks++; if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL bp_next_gnt: got %b want 0100", bus.gnt); end
    bus.req = 4'b0000;
    tick();
    tick();
    checks++; if (bus.res_id !== 2'd2) begin failures++; $display("FAIL bp_next_id: got %0d want 2", bus.res_id); end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  // Pointer is 3 here.
  task automatic test_wrap_skip();
    bus.req = 4'b1000;
    tick();
    checks++; if (bus.gnt !== 4'b1000) begin failures++; $display("FAIL wrap_gnt3: got %b want 1000", bus.gnt); end
    bus.req = 4'b0000;
    tick();
    tick();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    bus.req = 4'b0010;
    tick();
    checks++; if (bus.gnt !== 4'b0010) begin failures++; $display("FAIL wrap_skip_gnt: got %b want 0010", bus.gnt); end
    bus.req = 4'b0000;
    tick();
    tick();
    checks++; if (bus.res_id !== 2'd1) begin failures++; $display("FAIL wrap_skip_id: got %0d want 1", bus.res_id); end
    checks++; if (bus.res_out !== OUT_10000) begin failures++; $display("FAIL wrap_skip_out: got %h want %h", bus.res_out, OUT_10000); end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    // Pointer now 2: requesters 0 and 1 pending, search wraps past 3 to 0.
    bus.req = 4'b0011;
    tick();
    checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL wrap_search_gnt: got %b want 0001", bus.gnt); end
    bus.req = 4'b0000;
    tick();
    tick();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.req = 4'b0001;
    tick();
    bus.req = 4'b0000;
    tick();
    tick();
    checks++; if (bus.res_valid !== 1'b1) begin failures++; $display("FAIL mid_in_resp: got valid %b want 1", bus.res_valid); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL mid_valid: got %b want 0", bus.res_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
    checks++; if (bus.res_out !== 25'h0) begin failures++; $display("FAIL mid_out: got %h want 0", bus.res_out); end
    checks++; if (bus.res_id !== 2'd0) begin failures++; $display("FAIL mid_id: got %0d want 0", bus.res_id); end
    checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL mid_gnt: got %b want 0000", bus.gnt); end
`ifdef REP2_POPCNT_EN
    checks++; if (bus.res_cnt !== 5'd0) begin failures++; $display("FAIL mid_cnt: got %0d want 0", bus.res_cnt); end
`endif
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin failures++; $display("FAIL mid_no_replay: got busy %b gnt %b want 0 0000", bus.busy, bus.gnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_equal();
    test_round_robin();
    test_backpressure();
    test_wrap_skip();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
